// File: rtl/md_unit_pkg.sv
// Shared types and default latencies for the EX-stage multiply/divide unit.
package md_unit_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_t;

   localparam int unsigned MD_MULT_CYCLES = 32'd5;
   localparam int unsigned MD_DIV_CYCLES  = 32'd10;

   // Two's-complement negate used for the sign/magnitude divider.
   function automatic logic [31:0] md_neg(input logic [31:0] v);
      return 32'd0 - v;
   endfunction

endpackage

// File: rtl/md_unit_if.sv
// Operand/op request and HI/LO/busy response bundle between EX and md_unit.
interface md_unit_if;
   import md_unit_pkg::*;

   md_op_t      op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output op, output a, output b, input busy, input hi, input lo);
   modport slave  (input op, input a, input b, output busy, output hi, output lo);

endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; the result is computed at
// acceptance, parked in pend_hi/pend_lo and committed when the busy count expires.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic      clk,
   input  logic      reset,
   md_unit_if.slave  bus
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 32'd1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic [31:0]      r_pend_hi;
   logic [31:0]      r_pend_lo;

   logic [63:0]      w_prod_s;
   logic [63:0]      w_prod_u;
   logic             w_is_div_s;
   logic             w_den_zero;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [31:0]      w_a_mag;
   logic [31:0]      w_b_mag;
   logic [31:0]      w_q_mag;
   logic [31:0]      w_r_mag;
   logic [31:0]      w_quo;
   logic [31:0]      w_rem;
   logic [31:0]      w_res_hi;
   logic [31:0]      w_res_lo;
   logic             w_start;
   logic [CNT_W-1:0] w_len;

   assign w_prod_s = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
   assign w_prod_u = {32'd0, bus.a} * {32'd0, bus.b};

   // Signed division runs on magnitudes so the single unsigned divider serves
   // both div and divu; a zero divisor is steered to 1 and its result discarded.
   assign w_is_div_s = (bus.op == MD_DIV);
   assign w_den_zero = (bus.b == 32'd0);
   assign w_a_neg    = w_is_div_s & bus.a[31];
   assign w_b_neg    = w_is_div_s & bus.b[31];
   assign w_a_mag    = w_a_neg ? md_neg(bus.a) : bus.a;
   assign w_b_mag    = w_den_zero ? 32'd1 : (w_b_neg ? md_neg(bus.b) : bus.b);
   assign w_q_mag    = w_a_mag / w_b_mag;
   assign w_r_mag    = w_a_mag % w_b_mag;
   assign w_quo      = (w_a_neg ^ w_b_neg) ? md_neg(w_q_mag) : w_q_mag;
   assign w_rem      = w_a_neg ? md_neg(w_r_mag) : w_r_mag;

   // Selects the pending result and busy length for the op presented this cycle.
   always_comb begin
      w_res_hi = r_hi;
      w_res_lo = r_lo;
      w_start  = 1'b0;
      w_len    = '0;
      case (bus.op)
         MD_MULT: begin
            w_res_hi = w_prod_s[63:32];
            w_res_lo = w_prod_s[31:0];
            w_start  = 1'b1;
            w_len    = CNT_W'(MULT_CYCLES);
         end
         MD_MULTU: begin
            w_res_hi = w_prod_u[63:32];
            w_res_lo = w_prod_u[31:0];
            w_start  = 1'b1;
            w_len    = CNT_W'(MULT_CYCLES);
         end
         MD_DIV, MD_DIVU: begin
            if (w_den_zero) begin
               w_res_hi = r_hi;
               w_res_lo = r_lo;
            end else begin
               w_res_hi = w_rem;
               w_res_lo = w_quo;
            end
            w_start = 1'b1;
            w_len   = CNT_W'(DIV_CYCLES);
         end
         default: begin
            w_start = 1'b0;
         end
      endcase
   end

   // Busy countdown, HI/LO commit and idle-time mthi/mtlo writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
         if (r_cnt == CNT_W'(1)) begin
            r_hi   <= r_pend_hi;
            r_lo   <= r_pend_lo;
            r_busy <= 1'b0;
         end else begin
            r_busy <= 1'b1;
         end
      end else if (w_start) begin
         r_pend_hi <= w_res_hi;
         r_pend_lo <= w_res_lo;
         r_cnt     <= w_len;
         r_busy    <= 1'b1;
      end else begin
         case (bus.op)
            MD_MTHI: r_hi <= bus.a;
            MD_MTLO: r_lo <= bus.a;
            default: r_busy <= 1'b0;
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Randomized and directed check of md_unit against a plain-arithmetic HI/LO model.
module tb_md_unit;
   import md_unit_pkg::*;

   logic clk = 1'b0;
   logic clk_en = 1'b1;
   logic reset = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   md_unit_if mif ();

   md_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (mif.slave)
   );

   always #5 if (clk_en) clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void ref_md(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l);
      longint      sp;
      logic [63:0] up;
      longint      q;
      longint      r;
      case (op)
         MD_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            up = 64'(sp);
            h = up[63:32];
            l = up[31:0];
         end
         MD_MULTU: begin
            up = {32'd0, a} * {32'd0, b};
            h = up[63:32];
            l = up[31:0];
         end
         MD_DIV: if (b != 32'd0) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            l = 32'(q);
            h = 32'(r);
         end
         MD_DIVU: if (b != 32'd0) begin
            l = a / b;
            h = a % b;
         end
         MD_MTHI: h = a;
         MD_MTLO: l = a;
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Long op: busy for exactly N sampled cycles with HI/LO held, then commit.
   task automatic do_long(input md_op_t op, input logic [31:0] a, input logic [31:0] b, input bit junk);
      logic [31:0] nh;
      logic [31:0] nl;
      int n;
      nh = exp_hi;
      nl = exp_lo;
      ref_md(op, a, b, nh, nl);
      n = (op == MD_MULT || op == MD_MULTU) ? 5 : 10;
      @(negedge clk);
      mif.op = op; mif.a = a; mif.b = b;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("busy_run", 32'(mif.busy), 32'd1);
         check("hi_hold", mif.hi, exp_hi);
         check("lo_hold", mif.lo, exp_lo);
         if (junk) begin
            mif.op = md_op_t'($urandom_range(1, 6)); mif.a = $urandom; mif.b = $urandom;
         end else begin
            mif.op = MD_NONE;
         end
      end
      @(negedge clk);
      mif.op = MD_NONE;
      exp_hi = nh;
      exp_lo = nl;
      check("busy_done", 32'(mif.busy), 32'd0);
      check("hi_commit", mif.hi, exp_hi);
      check("lo_commit", mif.lo, exp_lo);
   endtask

   task automatic do_mt(input md_op_t op, input logic [31:0] a);
      @(negedge clk);
      mif.op = op; mif.a = a; mif.b = $urandom;
      @(negedge clk);
      mif.op = MD_NONE;
      ref_md(op, a, 32'd0, exp_hi, exp_lo);
      check("mt_busy", 32'(mif.busy), 32'd0);
      check("mt_hi", mif.hi, exp_hi);
      check("mt_lo", mif.lo, exp_lo);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      md_op_t op;
      mif.op = MD_NONE; mif.a = 32'd0; mif.b = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      check("rst_busy", 32'(mif.busy), 32'd0);
      check("rst_hi", mif.hi, 32'd0);
      check("rst_lo", mif.lo, 32'd0);

      do_long(MD_MULT,  32'hFFFF_FFFF, 32'd2, 1'b0);
      check("mult_hi_abs", mif.hi, 32'hFFFF_FFFF);
      check("mult_lo_abs", mif.lo, 32'hFFFF_FFFE);
      do_long(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
      check("multu_hi_abs", mif.hi, 32'h0000_0001);
      do_long(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
      check("div_lo_abs", mif.lo, 32'hFFFF_FFFD);
      check("div_hi_abs", mif.hi, 32'hFFFF_FFFF);
      do_long(MD_DIVU,  32'd7, 32'd2, 1'b0);
      check("divu_lo_abs", mif.lo, 32'd3);
      check("divu_hi_abs", mif.hi, 32'd1);
      do_long(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("ovf_lo_abs", mif.lo, 32'h8000_0000);
      check("ovf_hi_abs", mif.hi, 32'd0);

      do_mt(MD_MTHI, 32'h1234_5678);
      do_mt(MD_MTLO, 32'h9ABC_DEF0);
      do_long(MD_DIVU, 32'd5, 32'd0, 1'b0);
      check("dz_hi_abs", mif.hi, 32'h1234_5678);
      check("dz_lo_abs", mif.lo, 32'h9ABC_DEF0);
      do_mt(MD_MTHI, 32'hDEAD_BEEF);
      check("mthi_lo_abs", mif.lo, 32'h9ABC_DEF0);

      do_long(MD_MULT, 32'd3, 32'hFFFF_FFFB, 1'b1);
      check("coll_lo_abs", mif.lo, 32'hFFFF_FFF1);
      do_long(MD_DIV, 32'd100, 32'd7, 1'b1);

      for (int i = 0; i < 40; i++) begin
         op = md_op_t'($urandom_range(1, 6));
         if (op == MD_MTHI || op == MD_MTLO) do_mt(op, pick());
         else do_long(op, pick(), pick(), 1'($urandom_range(0, 1)));
      end

      // Reset with the clock stopped must clear outputs asynchronously.
      do_mt(MD_MTHI, 32'hA5A5_A5A5);
      do_mt(MD_MTLO, 32'h5A5A_5A5A);
      @(negedge clk);
      clk_en = 1'b0;
      #20 reset = 1'b0;
      #2;
      check("async_busy", 32'(mif.busy), 32'd0);
      check("async_hi", mif.hi, 32'd0);
      check("async_lo", mif.lo, 32'd0);
      #5 reset = 1'b1;
      clk_en = 1'b1;
      exp_hi = 32'd0;
      exp_lo = 32'd0;

      do_mt(MD_MTHI, 32'h1111_2222);
      @(negedge clk);
      mif.op = MD_DIV; mif.a = 32'd1000; mif.b = 32'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mif.op = MD_NONE;
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_busy", 32'(mif.busy), 32'd0);
      check("mid_hi", mif.hi, 32'd0);
      check("mid_lo", mif.lo, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         check("stale_busy", 32'(mif.busy), 32'd0);
         check("stale_hi", mif.hi, 32'd0);
         check("stale_lo", mif.lo, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
